// File: rtl/seq_stim_ctrl.sv
// seq_stim_ctrl
// Stimulus/scoreboard controller for a serial Mealy sequence detector.
// Latches a parallel sequence plus length, holds the detector in reset for
// CLR_CYCLES cycles, then streams the sequence MSB-first into the detector
// one bit per clock. It samples the detector output on every streamed bit
// and reports the hit count, the first-hit index and a full output trace.
//
// Handshake (start/busy/done): start is accepted only while the controller
// is in IDLE or DONE (busy=0). busy is high while a run is in progress
// (CLEAR and RUN). done pulses for exactly one cycle when a run completes
// normally, and the results are stable from that cycle until the next
// accepted start. abort ends a run early, raises the sticky aborted flag
// and suppresses done.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        launch request (IDLE/DONE only)
//   abort        cancel current run (CLEAR/RUN only)
//   seq_in       sequence, bit SEQ_W-1 is sent first
//   len          number of bits to send, clamped to SEQ_W
//   det_x        detector serial input
//   det_rst      detector synchronous reset
//   det_y        detector Mealy output, valid in the same cycle as det_x
//   busy, done   run in progress / one-cycle completion pulse
//   aborted      sticky abort flag
//   hit_count    number of sampled bits with det_y=1
//   first_hit    index of the first det_y=1, valid when hit_valid=1
//   y_trace      det_y for bit i is stored at position SEQ_W-1-i
//   dbg_state    current FSM state (0 IDLE, 1 CLEAR, 2 RUN, 3 DONE)
module seq_stim_ctrl #(
  parameter int SEQ_W      = 64,
  parameter int CNT_W      = 7,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SEQ_W-1:0] seq_in,
  input  logic [CNT_W-1:0] len,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_y,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] first_hit,
  output logic             hit_valid,
  output logic [SEQ_W-1:0] y_trace,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [SEQ_W-1:0] TOP_BIT = {1'b1, {(SEQ_W-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic [SEQ_W-1:0] r_shreg;
  logic [CNT_W-1:0] r_len;
  // Shared counter: CLEAR cycle count, then bit index during RUN.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_first_hit;
  logic             r_hit_valid;
  logic [SEQ_W-1:0] r_y_trace;
  logic             r_aborted;

  logic             w_accept;
  logic [CNT_W-1:0] w_len_clamp;
  logic             w_clr_last;
  logic             w_run_last;
  logic [SEQ_W-1:0] w_trace_bit;

  assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_len_clamp = (len > CNT_W'(SEQ_W)) ? CNT_W'(SEQ_W) : len;
  assign w_clr_last  = (r_cnt == CNT_W'(CLR_CYCLES - 1));
  assign w_run_last  = (r_cnt == (r_len - CNT_W'(1)));
  // Trace position for bit index r_cnt is SEQ_W-1-r_cnt.
  assign w_trace_bit = TOP_BIT >> r_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = (w_len_clamp == '0) ? S_DONE : S_CLEAR;
        else       w_next = S_IDLE;
      end
      S_CLEAR: begin
        if (abort)           w_next = S_IDLE;
        else if (w_clr_last) w_next = S_RUN;
      end
      S_RUN: begin
        // abort wins over the final-bit transition.
        if (abort)           w_next = S_IDLE;
        else if (w_run_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    det_rst = 1'b1;
    det_x   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_CLEAR: busy = 1'b1;
      S_RUN: begin
        busy    = 1'b1;
        det_rst = rst;
        det_x   = r_shreg[SEQ_W-1];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg     <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_hit_count <= '0;
      r_first_hit <= '0;
      r_hit_valid <= 1'b0;
      r_y_trace   <= '0;
      r_aborted   <= 1'b0;
    end else if (w_accept) begin
      r_shreg     <= seq_in;
      r_len       <= w_len_clamp;
      r_cnt       <= '0;
      r_hit_count <= '0;
      r_first_hit <= '0;
      r_hit_valid <= 1'b0;
      r_y_trace   <= '0;
      r_aborted   <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      if (abort)           r_aborted <= 1'b1;
      else if (w_clr_last) r_cnt     <= '0;
      else                 r_cnt     <= r_cnt + CNT_W'(1);
    end else if (r_state == S_RUN) begin
      // The sample in the abort cycle is still recorded.
      if (det_y) begin
        r_hit_count <= r_hit_count + CNT_W'(1);
        r_y_trace   <= r_y_trace | w_trace_bit;
        if (!r_hit_valid) begin
          r_first_hit <= r_cnt;
          r_hit_valid <= 1'b1;
        end
      end
      r_shreg <= {r_shreg[SEQ_W-2:0], 1'b0};
      r_cnt   <= r_cnt + CNT_W'(1);
      if (abort) r_aborted <= 1'b1;
    end
  end

  assign aborted   = r_aborted;
  assign hit_count = r_hit_count;
  assign first_hit = r_first_hit;
  assign hit_valid = r_hit_valid;
  assign y_trace   = r_y_trace;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Directed bench for seq_stim_ctrl. The detector model is y = x AND NOT
// previous x, where previous x is cleared while det_rst is high.
module tb_seq_stim_ctrl;

  localparam int SEQ_W      = 64;
  localparam int CNT_W      = 7;
  localparam int CLR_CYCLES = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [SEQ_W-1:0] seq_in;
  logic [CNT_W-1:0] len;
  logic             det_x;
  logic             det_rst;
  logic             det_y;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] first_hit;
  logic             hit_valid;
  logic [SEQ_W-1:0] y_trace;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected det_x bits, in send order.
  logic [0:0] exp_q[$];

  seq_stim_ctrl #(
    .SEQ_W      (SEQ_W),
    .CNT_W      (CNT_W),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .seq_in    (seq_in),
    .len       (len),
    .det_x     (det_x),
    .det_rst   (det_rst),
    .det_y     (det_y),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .hit_count (hit_count),
    .first_hit (first_hit),
    .hit_valid (hit_valid),
    .y_trace   (y_trace),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector model
  logic r_prev;
  always_ff @(posedge clk) begin
    if (det_rst) r_prev <= 1'b0;
    else         r_prev <= det_x;
  end
  assign det_y = det_x & ~r_prev;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [SEQ_W-1:0] s, input logic [CNT_W-1:0] l);
    seq_in = s;
    len    = l;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic load_exp(input logic [7:0] pat);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(pat[7-i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    logic [0:0]  e;
    int          n;

    rst = 1'b1; start = 1'b0; abort = 1'b0; seq_in = '0; len = '0;
    tick(); tick();
    // Reset state
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_det_rst", det_rst, 1);
    chk("rst_det_x", det_x, 0);
    chk("rst_results", {busy, done, aborted, hit_valid, hit_count, first_hit}, 0);
    chk("rst_trace", y_trace, 0);
    rst = 1'b0;
    tick();

    // 1: pattern 01011001, len 8, random filler below
    r64 = {$urandom(), $urandom()};
    load_exp(8'h59);
    launch({8'h59, r64[55:0]}, 7'd8);              // cycle t+1
    chk("t1_clear_state", dbg_state, ST_CLEAR);
    chk("t1_clear_rst1", det_rst, 1);
    chk("t1_busy", busy, 1);
    tick();                                         // t+2
    chk("t1_clear_rst2", det_rst, 1);
    chk("t1_clear_x", det_x, 0);
    tick();                                         // t+3
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("t1_x%0d", i), det_x, e);
      chk($sformatf("t1_rst%0d", i), det_rst, 0);
      chk($sformatf("t1_nodone%0d", i), done, 0);
      tick();
    end                                             // t+11
    chk("t1_done", done, 1);
    chk("t1_hits", hit_count, 3);
    chk("t1_first", first_hit, 1);
    chk("t1_valid", hit_valid, 1);
    chk("t1_trace", y_trace, {8'h51, 56'h0});

    // 5: back-to-back start in the done cycle
    seq_in = {8'h80, 56'h0};
    len    = 7'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("t5_no_gap", dbg_state, ST_CLEAR);
    chk("t5_cleared", hit_count, 0);
    tick(); tick();
    chk("t5_x", det_x, 1);
    tick();
    chk("t5_done", done, 1);
    chk("t5_hits", hit_count, 1);
    chk("t5_first", first_hit, 0);
    chk("t5_valid", hit_valid, 1);
    chk("t5_trace", y_trace, {8'h80, 56'h0});
    chk("t5_aborted", aborted, 0);
    tick();
    chk("t5_idle", dbg_state, ST_IDLE);
    chk("t5_hold", hit_count, 1);

    // 2: all zeros, len SEQ_W
    launch('0, 7'(SEQ_W));
    n = 1;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("t2_latency", n, SEQ_W + CLR_CYCLES + 1);
    chk("t2_hits", hit_count, 0);
    chk("t2_valid", hit_valid, 0);
    chk("t2_trace", y_trace, 0);
    tick();

    // 2b: all ones, len 127 clamps to SEQ_W; only bit 0 hits
    launch('1, 7'd127);
    n = 1;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("t2b_latency", n, SEQ_W + CLR_CYCLES + 1);
    chk("t2b_hits", hit_count, 1);
    chk("t2b_first", first_hit, 0);
    chk("t2b_trace", y_trace, {1'b1, 63'h0});
    tick();

    // 3: len 0 goes straight to DONE
    launch({8'hff, 56'h0}, 7'd0);                   // t+1
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_det_rst", det_rst, 1);
    chk("t3_results", {hit_valid, hit_count, first_hit}, 0);
    chk("t3_trace", y_trace, 0);
    tick();
    chk("t3_idle", dbg_state, ST_IDLE);
    chk("t3_busy2", busy, 0);

    // 4: abort while bit 4 is driven
    launch({8'h59, 56'h0}, 7'd8);                   // t+1
    tick(); tick();                                 // t+3 bit 0
    tick(); tick(); tick(); tick();                 // t+7 bit 4
    chk("t4_bit4", det_x, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_state", dbg_state, ST_IDLE);
    chk("t4_aborted", aborted, 1);
    chk("t4_done", done, 0);
    chk("t4_hits", hit_count, 2);
    chk("t4_first", first_hit, 1);
    chk("t4_trace", y_trace, {8'h50, 56'h0});
    tick();
    chk("t4_done2", done, 0);
    chk("t4_sticky", aborted, 1);
    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_idle_abort", dbg_state, ST_IDLE);

    // 6: rst mid-run; start during rst ignored
    launch({8'h59, 56'h0}, 7'd8);
    chk("t6_abort_clr", aborted, 0);
    tick(); tick(); tick(); tick();                 // bit 1 done, mid RUN
    chk("t6_in_run", dbg_state, ST_RUN);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("t6_state", dbg_state, ST_IDLE);
    chk("t6_det_rst", det_rst, 1);
    chk("t6_det_x", det_x, 0);
    chk("t6_outs", {busy, done, aborted, hit_valid, hit_count, first_hit}, 0);
    chk("t6_trace", y_trace, 0);
    tick();
    chk("t6_start_ign", dbg_state, ST_IDLE);
    chk("t6_nodone", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_stim_ctrl.md
Name: seq_stim_ctrl

Overview:
Stimulus/scoreboard controller for a serial Mealy-type sequence detector (1-bit input x, 1-bit output y, synchronous reset).
- Latches a parallel bit sequence and a length, then resets the detector.
- Streams the sequence into the detector MSB-first, one bit per clock.
- Samples the detector's Mealy output on every bit and reports hit count, first-hit index and a full output trace, with a start/busy/done handshake.
- Sits between a test/host sequencer and the detector instance; it owns the detector's x and reset pins.

Parameters:
SEQ_W, 64, maximum sequence length in bits; width of seq_in and y_trace.
CNT_W, 7, width of len, hit_count and first_hit; must satisfy 2^CNT_W > SEQ_W.
CLR_CYCLES, 2, number of cycles det_rst is held in CLEAR before streaming; must be ≥1.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
start  in  1  launch request; sampled only in IDLE or DONE.
abort  in  1  cancel the current run; sampled in CLEAR or RUN.
seq_in  in  SEQ_W  sequence; bit SEQ_W-1 is sent first; latched on accepted start.
len  in  CNT_W  number of bits to send; latched on accepted start; values >SEQ_W clamp to SEQ_W.
det_x  out  1  detector serial input.
det_rst  out  1  detector synchronous reset.
det_y  in  1  detector Mealy output; valid in the same cycle as det_x.
busy  out  1  high in CLEAR and RUN.
done  out  1  one-cycle pulse on normal completion.
aborted  out  1  sticky flag; set on abort, cleared on the next accepted start or on rst.
hit_count  out  CNT_W  number of sampled cycles with det_y=1.
first_hit  out  CNT_W  bit index (0-based) of the first det_y=1.
hit_valid  out  1  high once first_hit is valid.
y_trace  out  SEQ_W  det_y for bit i is stored at position SEQ_W-1-i; unsent positions are 0.

Behaviour:
- FSM states: IDLE, CLEAR, RUN, DONE. All outputs and state are registered except det_x and det_rst, which are decoded combinationally from state, shift register and rst.
- rst: state→IDLE; hit_count, first_hit, hit_valid, y_trace, aborted, done, internal index and shift register all →0.
  - det_rst = rst OR state≠RUN, so the detector is held in reset outside RUN.
  - det_x = 0 outside RUN.
- IDLE/DONE + start=1 at edge t:
  - latch seq_in into the shift register and the clamped len into the length register;
  - clear hit_count, first_hit, hit_valid, y_trace and aborted;
  - clear counter→0; state→CLEAR.
  - If the clamped len=0, go straight to DONE instead. done then pulses at cycle t+1 with all results 0.
- CLEAR: lasts exactly CLR_CYCLES cycles with det_rst=1, then →RUN.
- RUN:
  - det_rst=0; det_x = shreg[SEQ_W-1].
  - At each edge:
    - if det_y=1, increment hit_count;
    - if det_y=1 and hit_valid=0, set first_hit=index and hit_valid=1;
    - write y_trace[SEQ_W-1-index] = det_y;
    - shift shreg left by 1 with zero fill; increment index.
  - After the edge that samples index len-1, state→DONE.
- Latency: with start accepted at edge t, bit i is driven during cycle t+CLR_CYCLES+1+i. done is high during cycle t+CLR_CYCLES+len+1.
- DONE:
  - done=1 for this single cycle; then →IDLE, unless start=1, in which case the new run is accepted (back-to-back runs allowed).
  - Results hold their values until the next accepted start or rst.
- abort=1 in CLEAR or RUN:
  - state→IDLE at the next edge and aborted=1; no done pulse.
  - The RUN-cycle sample in which abort is seen is still recorded, so results reflect every bit sampled up to and including that cycle.
  - abort has priority over the final-bit transition to DONE.
- start while busy is ignored. abort in IDLE/DONE is ignored.
- rst mid-run overrides everything; done does not pulse.
- hit_count cannot overflow, since it is at most SEQ_W < 2^CNT_W.

Test Plan:
Bench detector model: y = x AND previous x equals 0, with previous x cleared by the detector reset. Use CLR_CYCLES=2.
1. seq_in top byte 8'b01011001, len=8, start at edge t → det_rst high for t+1..t+2; det_x = 0,1,0,1,1,0,0,1 over cycles t+3..t+10; done at t+11; hit_count=3, first_hit=1, hit_valid=1, y_trace top byte 8'b01010001.
2. seq_in all zeros, len=SEQ_W → done at t+SEQ_W+3; hit_count=0, hit_valid=0, y_trace=0.
3. len=0 → done at t+1; busy never high; det_rst stays 1; all results 0.
4. Same stimulus as 1, with abort asserted during the cycle driving bit 4 → IDLE next edge; aborted=1, no done; hit_count=2, first_hit=1, y_trace top byte 8'b01010000.
5. start re-asserted in the done cycle with seq 8'b10000000, len=1 → second run accepted with no IDLE gap; aborted stays 0; result hit_count=1, first_hit=0.
6. rst pulsed mid-RUN → next cycle all outputs 0, det_rst=1, det_x=0, state IDLE; a start asserted during rst is ignored.
